// File: rtl/rdi_sb_pkg.sv
// Shared definitions for the RDI sideband message arbiter: message numbers,
// arbiter state encoding and default timeout lengths.
package rdi_sb_pkg;

  // Sideband message numbers used by the PM entry and link-management sources
  localparam logic [3:0] Req_L1    = 4'd2;
  localparam logic [3:0] Req_L2    = 4'd3;
  localparam logic [3:0] Rsp_PMNAK = 4'd9;
  localparam logic [3:0] Rsp_L1    = 4'd10;
  localparam logic [3:0] Rsp_L2    = 4'd11;

  // Arbiter state; GAP differs from SEND in one bit so both "busy" states share bit 0
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b11
  } arb_state_e;

  // Grant timeout lengths equal to 2 us at the usual sideband clock rates
  localparam int TIMEOUT_CYC_100MHZ = 200;
  localparam int TIMEOUT_CYC_200MHZ = 400;

endpackage

// File: rtl/rdi_rr_picker.sv
// Round-robin pick among requesters 1..NUM_REQ-1. Requester 0 is handled by the
// strict-priority override in the arbiter, so bit 0 of the winner is always 0.
module rdi_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:1] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic               win_any
);

  // First valid requester at or above the pointer, else the first one below it
  always_comb begin
    win_oh  = '0;
    win_any = 1'b0;
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!win_any && req_valid[k] && (k >= int'(rr_ptr))) begin
        win_oh[k] = 1'b1;
        win_any   = 1'b1;
      end
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!win_any && req_valid[k] && (k < int'(rr_ptr))) begin
        win_oh[k] = 1'b1;
        win_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rdi_sb_msg_arbiter.sv
// Arbiter for the single RDI sideband message channel. Requester 0 (responses)
// wins outright; the others share the channel round-robin. One message per
// grant, ended by the sideband done or by a timeout, followed by a one-cycle gap.
module rdi_sb_msg_arbiter
  import rdi_sb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_200MHZ,
  parameter int CNT_W       = 9
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [4*NUM_REQ-1:0]       i_req_msg_no,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NUM_REQ-1:0]         o_req_done,
  output logic                       o_sb_msg_valid,
  output logic [3:0]                 o_sb_msg_no,
  input  logic                       i_sb_msg_done,
  output logic                       o_timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] o_timeout_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic               valid_d, err_d;
  logic [3:0]         msg_d;
  logic [IDX_W-1:0]   tidx_d;

  logic [NUM_REQ-1:0] rr_win;
  logic               rr_any;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_any;
  logic [IDX_W-1:0]   win_idx;
  logic [3:0]         win_msg;

  // Pointer after a completed grant to requester k: k+1, wrapping back to 1
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] k);
    if (int'(k) >= NUM_REQ - 1) return IDX_W'(1);
    return k + IDX_W'(1);
  endfunction

  rdi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_valid (i_req_valid[NUM_REQ-1:1]),
    .rr_ptr    (ptr_q),
    .win_oh    (rr_win),
    .win_any   (rr_any)
  );

  // Requester 0 overrides the round-robin winner; decode its index and message
  always_comb begin
    win_oh  = i_req_valid[0] ? NUM_REQ'(1) : rr_win;
    win_any = i_req_valid[0] | rr_any;
    win_idx = '0;
    win_msg = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_oh[k]) begin
        win_idx = IDX_W'(k);
        win_msg = i_req_msg_no[4*k +: 4];
      end
    end
  end

  // Next state and next register values for the grant FSM
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    done_d  = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    msg_d   = o_sb_msg_no;
    tidx_d  = o_timeout_idx;

    if (i_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            state_d = SEND;
            owner_d = win_idx;
            grant_d = win_oh;
            valid_d = 1'b1;
            msg_d   = win_msg;
            cnt_d   = '0;
          end
        end
        SEND: begin
          grant_d = o_grant;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          // done beats a timeout that expires in the same cycle
          if (i_sb_msg_done) begin
            state_d = GAP;
            grant_d = '0;
            valid_d = 1'b0;
            done_d  = o_grant;
            if (owner_q != '0) ptr_d = next_ptr(owner_q);
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = GAP;
            grant_d = '0;
            valid_d = 1'b0;
            err_d   = 1'b1;
            tidx_d  = owner_q;
            if (owner_q != '0) ptr_d = next_ptr(owner_q);
          end
        end
        GAP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, latches and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      ptr_q          <= IDX_W'(1);
      cnt_q          <= '0;
      o_grant        <= '0;
      o_req_done     <= '0;
      o_sb_msg_valid <= 1'b0;
      o_sb_msg_no    <= '0;
      o_timeout_err  <= 1'b0;
      o_timeout_idx  <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      o_grant        <= grant_d;
      o_req_done     <= done_d;
      o_sb_msg_valid <= valid_d;
      o_sb_msg_no    <= msg_d;
      o_timeout_err  <= err_d;
      o_timeout_idx  <= tidx_d;
    end
  end

endmodule

// File: tb/tb_rdi_sb_msg_arbiter.sv
// Self-checking bench for rdi_sb_msg_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a transaction model.
module tb_rdi_sb_msg_arbiter;

  localparam int NUM_REQ = 3;
  localparam int TO_CYC  = 400;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [4*NUM_REQ-1:0] req_no = '0;
  logic                 sb_done = 1'b0;
  logic [NUM_REQ-1:0]   o_grant, o_req_done;
  logic                 o_sb_msg_valid, o_timeout_err;
  logic [3:0]           o_sb_msg_no;
  logic [1:0]           o_timeout_idx;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: current owner (-1 = channel free), message age, gap pending
  int                 m_owner, m_age, m_ptr, m_tidx;
  bit                 m_gap;
  logic [3:0]         m_no;
  logic [NUM_REQ-1:0] e_done;
  logic               e_err;

  int got[$];
  int ptrs[$];
  int min_gap;

  rdi_sb_msg_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TO_CYC),
    .CNT_W       (9)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_req_valid    (req_valid),
    .i_req_msg_no   (req_no),
    .o_grant        (o_grant),
    .o_req_done     (o_req_done),
    .o_sb_msg_valid (o_sb_msg_valid),
    .o_sb_msg_no    (o_sb_msg_no),
    .i_sb_msg_done  (sb_done),
    .o_timeout_err  (o_timeout_err),
    .o_timeout_idx  (o_timeout_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic void model_reset();
    m_owner = -1; m_age = 0; m_ptr = 1; m_tidx = 0; m_gap = 0;
    m_no = '0; e_done = '0; e_err = 1'b0;
  endfunction

  // A finished message hands the turn to the requester after its owner
  function automatic void model_retire();
    if (m_owner != 0) m_ptr = (m_owner % (NUM_REQ - 1)) + 1;
    m_owner = -1;
    m_gap   = 1'b1;
  endfunction

  function automatic void model_step();
    int w;
    e_done = '0;
    e_err  = 1'b0;
    if (flush) begin
      m_owner = -1;
      m_gap   = 1'b0;
    end else if (m_owner >= 0) begin
      if (sb_done) begin
        e_done = NUM_REQ'(1) << m_owner;
        model_retire();
      end else if (m_age == TO_CYC - 1) begin
        e_err  = 1'b1;
        m_tidx = m_owner;
        model_retire();
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      w = -1;
      if (req_valid[0]) w = 0;
      for (int j = 0; j < NUM_REQ - 1 && w < 0; j++) begin
        int k;
        k = 1 + ((m_ptr - 1 + j) % (NUM_REQ - 1));
        if (((req_valid >> k) & 1) != 0) w = k;
      end
      if (w >= 0) begin
        m_owner = w;
        m_age   = 0;
        m_no    = 4'(req_no >> (4 * w));
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("grant",  32'(o_grant),        (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check_eq("valid",  32'(o_sb_msg_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_eq("msg_no", 32'(o_sb_msg_no),    32'(m_no));
    check_eq("done",   32'(o_req_done),     32'(e_done));
    check_eq("err",    32'(o_timeout_err),  32'(e_err));
    check_eq("tidx",   32'(o_timeout_idx),  32'(m_tidx));
    check_eq("ptr",    32'(dut.ptr_q),      32'(m_ptr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic settle();
    req_valid = '0; flush = 1'b0; sb_done = 1'b0;
    repeat (3) cycle();
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int k = 0; k < NUM_REQ; k++) if (((v >> k) & 1) != 0) r = k;
    return r;
  endfunction

  // Sideband that finishes each message after two cycles; sources drop at done
  task automatic serve(input int n_msgs, input bit repeat_req, input int bound);
    bit prev_v = 0;
    int age = 0;
    int low_run = 0;
    logic [NUM_REQ-1:0] reraise = '0;
    got.delete(); ptrs.delete(); min_gap = 1000;
    for (int c = 0; c < bound && ptrs.size() < n_msgs; c++) begin
      req_valid = req_valid | reraise;
      reraise = '0;
      cycle();
      if (o_sb_msg_valid && !prev_v) begin
        got.push_back(onehot_idx(o_grant));
        if (got.size() > 1 && low_run < min_gap) min_gap = low_run;
      end
      low_run = o_sb_msg_valid ? 0 : low_run + 1;
      age     = o_sb_msg_valid ? age + 1 : 0;
      sb_done = o_sb_msg_valid && (age >= 2);
      if (o_req_done != '0) begin
        req_valid = req_valid & ~o_req_done;
        if (repeat_req) reraise = o_req_done;
        ptrs.push_back(int'(dut.ptr_q));
      end
      prev_v = o_sb_msg_valid;
    end
    sb_done = 1'b0;
    check_eq("serve_cnt", 32'(ptrs.size()), 32'(n_msgs));
  endtask

  initial begin
    int n;
    logic [NUM_REQ-1:0] seen_done;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_grant", 32'(o_grant), 0);
    check_eq("rst_valid", 32'(o_sb_msg_valid), 0);
    check_eq("rst_no",    32'(o_sb_msg_no), 0);
    check_eq("rst_done",  32'(o_req_done), 0);
    check_eq("rst_err",   32'(o_timeout_err), 0);
    check_eq("rst_tidx",  32'(o_timeout_idx), 0);
    check_eq("rst_ptr",   32'(dut.ptr_q), 1);
    rst_n = 1'b1;
    settle();

    // Single request from requester 1
    req_valid = 3'b010; req_no = 12'h020;
    cycle();
    check_eq("single_grant", 32'(o_grant), 32'h2);
    check_eq("single_valid", 32'(o_sb_msg_valid), 1);
    check_eq("single_no",    32'(o_sb_msg_no), 2);
    repeat (4) cycle();
    sb_done = 1'b1;
    cycle();
    check_eq("single_done",  32'(o_req_done), 32'h2);
    check_eq("single_drop",  32'(o_sb_msg_valid), 0);
    sb_done = 1'b0; req_valid = '0;
    settle();

    // Strict priority of requester 0 over requester 2
    req_valid = 3'b101; req_no = {4'd3, 4'd0, 4'd10};
    serve(2, 1'b0, 60);
    check_eq("prio_first",  32'(got.size() > 0 ? got[0] : -1), 0);
    check_eq("prio_second", 32'(got.size() > 1 ? got[1] : -1), 2);
    check_eq("prio_gap",    32'(min_gap >= 1), 1);
    settle();

    // Round-robin between requesters 1 and 2
    req_valid = 3'b110; req_no = {4'd3, 4'd2, 4'd0};
    serve(4, 1'b1, 100);
    for (int i = 0; i < 4; i++) begin
      check_eq("rr_order", 32'(got.size() > i ? got[i] : -1),  32'((i % 2 == 0) ? 1 : 2));
      check_eq("rr_ptr",   32'(ptrs.size() > i ? ptrs[i] : -1), 32'((i % 2 == 0) ? 2 : 1));
    end
    settle();

    // Timeout on requester 2
    req_valid = 3'b100; req_no = {4'd11, 8'h00};
    cycle();
    n = 0; seen_done = '0;
    while (!o_timeout_err && n < 500) begin
      cycle();
      seen_done = seen_done | o_req_done;
      n++;
    end
    check_eq("to_latency", 32'(n), 32'(TO_CYC));
    check_eq("to_idx",     32'(o_timeout_idx), 2);
    check_eq("to_nodone",  32'(seen_done), 0);
    settle();

    // Done in the same cycle the timeout would fire
    req_valid = 3'b010; req_no = 12'h030;
    cycle();
    repeat (TO_CYC - 1) cycle();
    sb_done = 1'b1;
    cycle();
    check_eq("race_done", 32'(o_req_done), 32'h2);
    check_eq("race_err",  32'(o_timeout_err), 0);
    sb_done = 1'b0; req_valid = '0;
    settle();

    // Flush in the middle of a message
    req_valid = 3'b100; req_no = {4'd9, 8'h00};
    repeat (3) cycle();
    flush = 1'b1; req_valid = '0;
    cycle();
    check_eq("flush_valid", 32'(o_sb_msg_valid), 0);
    check_eq("flush_grant", 32'(o_grant), 0);
    check_eq("flush_done",  32'(o_req_done), 0);
    check_eq("flush_ptr",   32'(dut.ptr_q), 2);
    flush = 1'b0;
    settle();

    // Message number latched at grant; later input changes ignored
    req_valid = 3'b010; req_no = 12'h020;
    cycle();
    req_no = 12'h090;
    repeat (2) cycle();
    check_eq("stable_no", 32'(o_sb_msg_no), 2);

    // Asynchronous reset mid-message
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(o_sb_msg_valid), 0);
    check_eq("arst_grant", 32'(o_grant), 0);
    check_eq("arst_no",    32'(o_sb_msg_no), 0);
    check_eq("arst_done",  32'(o_req_done), 0);
    model_reset();
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if ($urandom_range(3) == 0) req_valid = req_valid | (NUM_REQ'(1) << k);
      req_no  = 12'($urandom);
      flush   = ($urandom_range(63) == 0);
      sb_done = ($urandom_range(2) == 0);
      cycle();
      req_valid = req_valid & ~e_done;
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rdi_sb_msg_arbiter.md
Name: rdi_sb_msg_arbiter

Overview:
- Shares the single RDI sideband message channel between several message sources: PM entry TX requests, PM entry RX responses, and link-management sources.
- Requester 0 (responses) has strict priority. Requesters 1..NUM_REQ-1 are served round-robin.
- Each grant carries one message. The grant ends on the sideband done signal or on a timeout.
- Sources receive a private done pulse, so no source has to infer ownership of a shared done signal.

Parameters:
- NUM_REQ, 3, number of requesters; must be >= 2.
- TIMEOUT_CYC, 400, cycles a grant may stay in SEND without i_sb_msg_done (2 us at 200 MHz).
- CNT_W, 9, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous abort of the current grant
- i_req_valid  in  NUM_REQ  per-requester message request, held until its done pulse
- i_req_msg_no  in  4*NUM_REQ  per-requester message number; slice k = bits [4k+3:4k]
- o_grant  out  NUM_REQ  one-hot owner of the channel, all zero when no owner
- o_req_done  out  NUM_REQ  one-cycle pulse to the owner when its message completes
- o_sb_msg_valid  out  1  message valid toward the sideband
- o_sb_msg_no  out  4  message number toward the sideband
- i_sb_msg_done  in  1  sideband finished sending the current message
- o_timeout_err  out  1  one-cycle pulse when a grant times out
- o_timeout_idx  out  $clog2(NUM_REQ)  index of the timed-out requester, held until the next timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0; RR pointer 1.
- States:
  - IDLE: wait for a request.
  - SEND: message in flight.
  - GAP: mandatory one-cycle separation between messages.
- IDLE:
  - Winner = requester 0 if valid; otherwise the first valid requester at or after the RR pointer, searching 1..NUM_REQ-1 with wrap back to 1.
  - On a winner: latch its index and i_req_msg_no slice, go to SEND.
  - o_grant, o_sb_msg_valid and o_sb_msg_no are registered and all assert in the cycle after the request is first sampled (1-cycle latency).
- SEND:
  - o_sb_msg_valid stays 1 and o_sb_msg_no stays at the latched value; later changes to the requester's inputs are ignored.
  - The counter increments every SEND cycle.
  - On i_sb_msg_done: pulse o_req_done[owner] in the next cycle, drop valid and grant, go to GAP.
  - If the counter reaches TIMEOUT_CYC-1 with no done: pulse o_timeout_err, load o_timeout_idx, drop valid and grant, go to GAP. No o_req_done is issued.
  - Done and timeout in the same cycle: done wins and no error is raised.
- GAP:
  - o_sb_msg_valid stays 0 for this one cycle.
  - All i_req_valid inputs are ignored. The owner must drop i_req_valid at the end of the cycle carrying its done pulse.
  - Go to IDLE next cycle.
- RR pointer:
  - Updated only when a grant to requester k (k >= 1) completes by done or timeout: pointer = k+1, wrapping NUM_REQ to 1.
  - Grants to requester 0 leave the pointer unchanged.
- i_flush has the highest priority in every state:
  - Next cycle: state IDLE, valid/grant/done/error all 0, counter cleared.
  - RR pointer and o_timeout_idx are kept.
  - Flush during IDLE has no effect other than blocking arbitration in that cycle.
- i_sb_msg_done outside SEND is ignored.
- The counter is cleared on entry to SEND and on flush.
- Reset mid-SEND: all outputs clear immediately (asynchronous reset), and no done pulse is issued.
- o_sb_msg_no holds its last value after valid drops, until the next grant.

Decomposition:
- Package rdi_sb_pkg holds:
  - Message-number constants: Req_L1=2, Req_L2=3, Rsp_PMNAK=9, Rsp_L1=10, Rsp_L2=11.
  - The 2-bit state encoding: IDLE=00, SEND=01, GAP=11.
  - The default timeout constants for 100 MHz (200) and 200 MHz (400).
- One combinational sub-module, rdi_rr_picker: inputs are the valid vector and the pointer; outputs are a one-hot winner and an any-valid flag. It covers requesters 1..NUM_REQ-1 only.
- The FSM, strict-priority override, latches and counter stay in the top level.

Test Plan:
- Single request: req1 valid with msg_no=2 at cycle 0 -> cycle 1: o_grant=010, o_sb_msg_valid=1, o_sb_msg_no=2. Done at cycle 5 -> o_req_done=010 at cycle 6, valid=0 at cycle 6.
- Priority: req0 (msg 10) and req2 (msg 3) raised in the same cycle -> req0 served first. req2 is granted only after the GAP cycle, with no valid-high overlap and at least one valid-low cycle between the two messages.
- Round-robin: req1 and req2 held continuously, req0 idle -> grant order 1,2,1,2. Pointer reads 2,1,2,1 after each completion.
- Timeout: req2 granted and i_sb_msg_done never asserted -> o_timeout_err pulses exactly 400 cycles after o_sb_msg_valid rose, o_timeout_idx=2, no o_req_done.
- Race and flush:
  - Done asserted in the cycle the counter hits 399 -> o_req_done pulses, o_timeout_err stays 0.
  - i_flush during SEND -> valid and grant drop the next cycle, no done, pointer unchanged.
- Input stability and reset: changing i_req_msg_no from 2 to 9 mid-SEND leaves o_sb_msg_no=2. Asserting i_rst_n low mid-SEND clears all outputs asynchronously.
